// File: rtl/pll_mdrp_pkg.sv
// rtl/pll_mdrp_pkg.sv - shared opcodes and register map constants for the PLL MDRP responder
package pll_mdrp_pkg;

    localparam logic [1:0] MDOPC_NOP = 2'b00;
    localparam logic [1:0] MDOPC_WR  = 2'b01;
    localparam logic [1:0] MDOPC_RD  = 2'b10;
    localparam logic [1:0] MDOPC_ALD = 2'b11;

    localparam int         CTRL_COMMIT   = 0;
    localparam logic [7:0] MULT_FAC_ADDR = 8'h00;

    typedef enum logic {
        ST_RELOCK = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

endpackage

// File: rtl/pll_mdrp_responder_if.sv
// rtl/pll_mdrp_responder_if.sv - MDRP bus between the PLL init sequencer and the responder
interface pll_mdrp_responder_if;

    logic [1:0] mdopc;
    logic       mdainc;
    logic [7:0] mdwdi;
    logic [7:0] mdrdo;
    logic       lock;
    logic [7:0] mult_fac;
    logic       busy;

    modport master (
        output mdopc, mdainc, mdwdi,
        input  mdrdo, lock, mult_fac, busy
    );

    modport slave (
        input  mdopc, mdainc, mdwdi,
        output mdrdo, lock, mult_fac, busy
    );

endinterface

// File: rtl/pll_lock_timer.sv
// rtl/pll_lock_timer.sv - relock count-down; lock rises LOCK_DELAY cycles after reset release or restart
module pll_lock_timer
    import pll_mdrp_pkg::*;
#(
    parameter int LOCK_DELAY = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic lock
);

    localparam int CW = $clog2(LOCK_DELAY + 1);

    lock_state_t   state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RELOCK;
            cnt   <= CW'(LOCK_DELAY);
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The final decrement (1 -> 0) and the lock assertion share an edge, so lock
    // reads high exactly LOCK_DELAY edges after the load edge.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (restart) begin
            state_nxt = ST_RELOCK;
            cnt_nxt   = CW'(LOCK_DELAY);
        end else begin
            case (state)
                ST_RELOCK: begin
                    if (cnt <= CW'(1)) begin
                        state_nxt = ST_LOCKED;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - CW'(1);
                    end
                end
                ST_LOCKED: begin
                    cnt_nxt = '0;
                end
                default: begin
                    state_nxt = ST_RELOCK;
                    cnt_nxt   = CW'(LOCK_DELAY);
                end
            endcase
        end
    end

    assign lock = (state == ST_LOCKED);

endmodule

// File: rtl/pll_mdrp_responder.sv
// rtl/pll_mdrp_responder.sv - MDRP responder: pointer-addressed config register file with modelled PLL lock
module pll_mdrp_responder
    import pll_mdrp_pkg::*;
#(
    parameter logic [7:0] MULTI_FAC  = 8'd53,
    parameter int         NREGS      = 16,
    parameter int         LOCK_DELAY = 64
) (
    input  logic                 mdclk,
    input  logic                 reset,
    pll_mdrp_responder_if.slave  bus
);

    localparam int            AW        = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [7:0]    CTRL_ADDR = 8'(NREGS - 1);
    localparam logic [AW-1:0] MF_IDX    = AW'(MULT_FAC_ADDR);

    logic [7:0]    addr;
    logic [7:0]    regs [NREGS];
    logic [7:0]    rdo_q;
    logic [7:0]    wr_data;
    logic [AW-1:0] idx;
    logic          in_range;
    logic          is_wr;
    logic          is_rd;
    logic          is_ald;
    logic          commit;
    logic          lock_w;

    assign idx      = addr[AW-1:0];
    assign in_range = ({1'b0, addr} < 9'(NREGS));
    assign is_wr    = (bus.mdopc == MDOPC_WR);
    assign is_rd    = (bus.mdopc == MDOPC_RD);
    assign is_ald   = (bus.mdopc == MDOPC_ALD);
    assign commit   = is_wr && (addr == CTRL_ADDR) && bus.mdwdi[CTRL_COMMIT];

    // The commit bit is a strobe: it is never stored in CTRL.
    always_comb begin
        wr_data = bus.mdwdi;
        if (addr == CTRL_ADDR) begin
            wr_data[CTRL_COMMIT] = 1'b0;
        end
    end

    always_ff @(posedge mdclk) begin
        if (reset) begin
            addr  <= 8'h00;
            rdo_q <= 8'h00;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= (i == int'(MULT_FAC_ADDR)) ? MULTI_FAC : 8'h00;
            end
        end else begin
            if (is_wr && in_range) begin
                regs[idx] <= wr_data;
            end
            if (is_rd) begin
                rdo_q <= in_range ? regs[idx] : 8'h00;
            end
            // Address load takes precedence over the post-increment strobe.
            if (is_ald) begin
                addr <= bus.mdwdi;
            end else if (bus.mdainc) begin
                addr <= addr + 8'h01;
            end
        end
    end

    pll_lock_timer #(
        .LOCK_DELAY (LOCK_DELAY)
    ) u_lock_timer (
        .clk     (mdclk),
        .reset   (reset),
        .restart (commit),
        .lock    (lock_w)
    );

    assign bus.mdrdo    = rdo_q;
    assign bus.lock     = lock_w;
    assign bus.busy     = ~lock_w;
    assign bus.mult_fac = regs[MF_IDX];

endmodule

// File: tb/tb_pll_mdrp_responder.sv
// tb/tb_pll_mdrp_responder.sv - directed vector bench for pll_mdrp_responder
module tb_pll_mdrp_responder;
    import pll_mdrp_pkg::*;

    typedef struct {
        logic [1:0] opc;
        logic       ainc;
        logic [7:0] wdi;
        logic [7:0] rdo;
        logic [7:0] mult;
    } vec_t;

    logic mdclk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[$];

    always #5 mdclk = ~mdclk;

    pll_mdrp_responder_if bus();

    pll_mdrp_responder #(
        .MULTI_FAC  (8'd53),
        .NREGS      (16),
        .LOCK_DELAY (64)
    ) dut (
        .mdclk (mdclk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [1:0] opc, input logic ainc, input logic [7:0] wdi);
        bus.mdopc  = opc;
        bus.mdainc = ainc;
        bus.mdwdi  = wdi;
        @(posedge mdclk);
        #1;
    endtask

    task automatic count_lock(input int start, input int exp, input string nm);
        int n;
        n = start;
        while (bus.lock !== 1'b1 && n < 200) begin
            step(MDOPC_NOP, 1'b0, 8'h00);
            n++;
        end
        check(nm, n, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back(vec_t'{MDOPC_ALD, 1'b0, 8'h03, 8'h00, 8'h35});
        vecs.push_back(vec_t'{MDOPC_WR,  1'b1, 8'hA5, 8'h00, 8'h35});
        vecs.push_back(vec_t'{MDOPC_WR,  1'b0, 8'h5A, 8'h00, 8'h35});
        vecs.push_back(vec_t'{MDOPC_ALD, 1'b0, 8'h03, 8'h00, 8'h35});
        vecs.push_back(vec_t'{MDOPC_RD,  1'b1, 8'h00, 8'hA5, 8'h35});
        vecs.push_back(vec_t'{MDOPC_RD,  1'b0, 8'h00, 8'h5A, 8'h35});
        vecs.push_back(vec_t'{MDOPC_ALD, 1'b1, 8'hFF, 8'h5A, 8'h35});
        vecs.push_back(vec_t'{MDOPC_NOP, 1'b1, 8'h00, 8'h5A, 8'h35});
        vecs.push_back(vec_t'{MDOPC_RD,  1'b0, 8'h00, 8'h35, 8'h35});
        vecs.push_back(vec_t'{MDOPC_ALD, 1'b0, 8'h20, 8'h35, 8'h35});
        vecs.push_back(vec_t'{MDOPC_WR,  1'b0, 8'h77, 8'h35, 8'h35});
        vecs.push_back(vec_t'{MDOPC_RD,  1'b0, 8'h00, 8'h00, 8'h35});
        vecs.push_back(vec_t'{MDOPC_ALD, 1'b0, 8'h00, 8'h00, 8'h35});
        vecs.push_back(vec_t'{MDOPC_RD,  1'b0, 8'h00, 8'h35, 8'h35});
        vecs.push_back(vec_t'{MDOPC_ALD, 1'b0, 8'h03, 8'h35, 8'h35});
        vecs.push_back(vec_t'{MDOPC_RD,  1'b1, 8'h00, 8'hA5, 8'h35});
        vecs.push_back(vec_t'{MDOPC_RD,  1'b1, 8'h00, 8'h5A, 8'h35});
        vecs.push_back(vec_t'{MDOPC_RD,  1'b0, 8'h00, 8'h00, 8'h35});
        vecs.push_back(vec_t'{MDOPC_ALD, 1'b0, 8'h07, 8'h00, 8'h35});
        vecs.push_back(vec_t'{MDOPC_WR,  1'b0, 8'h3C, 8'h00, 8'h35});
        vecs.push_back(vec_t'{MDOPC_RD,  1'b0, 8'h00, 8'h3C, 8'h35});

        // Reset state and initial lock delay
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step(MDOPC_NOP, 1'b0, 8'h00);
        check("rst_lock", bus.lock, 1'b0);
        check("rst_busy", bus.busy, 1'b1);
        check("rst_mult", bus.mult_fac, 8'h35);
        check("rst_rdo", bus.mdrdo, 8'h00);
        reset = 1'b0;
        count_lock(0, 64, "t1_lock_delay");
        check("t1_busy", bus.busy, 1'b0);

        // Register access vectors
        foreach (vecs[i]) begin
            step(vecs[i].opc, vecs[i].ainc, vecs[i].wdi);
            check($sformatf("vec%0d_rdo", i), bus.mdrdo, vecs[i].rdo);
            check($sformatf("vec%0d_mult", i), bus.mult_fac, vecs[i].mult);
            check($sformatf("vec%0d_lock", i), bus.lock, 1'b1);
        end

        // Commit, then a second commit 30 cycles into the relock
        step(MDOPC_ALD, 1'b0, 8'h00);
        step(MDOPC_WR, 1'b0, 8'h40);
        check("t5_mult", bus.mult_fac, 8'h40);
        step(MDOPC_ALD, 1'b0, 8'h0F);
        step(MDOPC_WR, 1'b0, 8'h81);
        check("t5_commit_drop", bus.lock, 1'b0);
        check("t5_busy", bus.busy, 1'b1);
        step(MDOPC_RD, 1'b0, 8'h00);
        check("t5_ctrl_rd", bus.mdrdo, 8'h80);
        for (int k = 2; k < 30; k++) step(MDOPC_NOP, 1'b0, 8'h00);
        check("t5_still_relock", bus.lock, 1'b0);
        step(MDOPC_WR, 1'b0, 8'h81);
        check("t5_recommit_lock", bus.lock, 1'b0);
        step(MDOPC_RD, 1'b0, 8'h00);
        check("t5_ctrl_rd2", bus.mdrdo, 8'h80);
        count_lock(1, 64, "t5_recommit_delay");

        // Reset mid-relock and mid-sequence
        step(MDOPC_ALD, 1'b0, 8'h05);
        step(MDOPC_WR, 1'b0, 8'h99);
        step(MDOPC_ALD, 1'b0, 8'h00);
        step(MDOPC_WR, 1'b0, 8'h12);
        check("t6_mult_pre", bus.mult_fac, 8'h12);
        step(MDOPC_ALD, 1'b0, 8'h0F);
        step(MDOPC_WR, 1'b0, 8'h81);
        for (int k = 0; k < 10; k++) step(MDOPC_NOP, 1'b0, 8'h00);
        step(MDOPC_ALD, 1'b0, 8'h06);
        reset = 1'b1;
        step(MDOPC_NOP, 1'b0, 8'h00);
        step(MDOPC_NOP, 1'b0, 8'h00);
        check("t6_rst_mult", bus.mult_fac, 8'h35);
        check("t6_rst_lock", bus.lock, 1'b0);
        check("t6_rst_rdo", bus.mdrdo, 8'h00);
        reset = 1'b0;
        step(MDOPC_RD, 1'b0, 8'h00);
        check("t6_addr0_rd", bus.mdrdo, 8'h35);
        count_lock(1, 64, "t6_relock_delay");
        step(MDOPC_ALD, 1'b0, 8'h05);
        step(MDOPC_RD, 1'b0, 8'h00);
        check("t6_reg5_clr", bus.mdrdo, 8'h00);
        step(MDOPC_ALD, 1'b0, 8'h0F);
        step(MDOPC_RD, 1'b0, 8'h00);
        check("t6_ctrl_clr", bus.mdrdo, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
